// File: rtl/sar_ref_pkg.sv
// Shared definitions for the SAR reference monitor: FSM state type,
// default geometry constants and a small elaboration-time helper.
package sar_ref_pkg;

  // Default converter geometry
  localparam int DEF_N_BITS        = 8;
  localparam int DEF_SAMPLE_CYCLES = 4;
  localparam int DEF_SETTLE_CYCLES = 3;

  // Converter sequencing states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SAMPLE  = 2'd1,
    ST_CONVERT = 2'd2,
    ST_DONE    = 2'd3
  } sar_state_t;

  // Larger of two integers, used to size shared counters
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sar_ref_sync2.sv
// Two-flop synchronizer bringing the asynchronous comparator decision
// into the clk domain. Reset clears both stages.
module sar_ref_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  localparam int STAGES = 2;

  logic [STAGES-1:0] stage_reg;

  // Shift the raw input through the metastability-settling stages
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_reg <= '0;
    end else begin
      stage_reg <= {stage_reg[STAGES-2:0], d};
    end
  end

  assign q = stage_reg[STAGES-1];

endmodule

// File: rtl/sar_ref_monitor.sv
// Successive-approximation converter controller with optional window alarm.
// Sequence: IDLE -> SAMPLE (track/hold) -> CONVERT (MSB first, one trial
// bit per settle window) -> DONE (one-cycle result pulse) -> IDLE.
// The comparator is only observed through a 2-flop synchronizer, so each
// trial bit is decided in the last cycle of its settle window.
// Optional feature: define SAR_REF_MONITOR_ALARM_EN to build the threshold
// alarm; without it alarm_o is tied low and the thresholds are ignored.
module sar_ref_monitor
  import sar_ref_pkg::*;
#(
  parameter int N_BITS        = DEF_N_BITS,
  parameter int SAMPLE_CYCLES = DEF_SAMPLE_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              start_i,
  input  logic              comp_i,
  input  logic [N_BITS-1:0] thr_lo_i,
  input  logic [N_BITS-1:0] thr_hi_i,
  output logic [N_BITS-1:0] dac_code_o,
  output logic              sample_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [N_BITS-1:0] result_o,
  output logic              alarm_o
);

  // One counter serves both the sample window and each settle window
  localparam int CNT_MAX = max_int(SAMPLE_CYCLES, SETTLE_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = (N_BITS > 1) ? $clog2(N_BITS) : 1;

  localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [IDX_W-1:0] MSB_IDX     = IDX_W'(N_BITS - 1);

  sar_state_t        state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [IDX_W-1:0]  bit_idx_reg, bit_idx_next;
  logic [N_BITS-1:0] kept_reg, kept_next;
  logic [N_BITS-1:0] result_reg;
  logic [N_BITS-1:0] trial_mask;
  logic [N_BITS-1:0] final_code;
  logic              load_result;
  logic              comp_sync;

  // Comparator enters the clock domain here and nowhere else
  sar_ref_sync2 u_comp_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (comp_i),
    .q     (comp_sync)
  );

  // One-hot mask of the bit currently under trial
  genvar gi;
  generate
    for (gi = 0; gi < N_BITS; gi++) begin : g_mask
      assign trial_mask[gi] = (bit_idx_reg == IDX_W'(gi));
    end
  endgenerate

  // Kept bits after the comparator verdict on the current trial bit
  assign final_code = kept_reg | (comp_sync ? trial_mask : '0);

  // State, window counter, bit index and kept-code registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      bit_idx_reg <= MSB_IDX;
      kept_reg    <= '0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      bit_idx_reg <= bit_idx_next;
      kept_reg    <= kept_next;
    end
  end

  // Next-state sequencing; a low enable overrides everything and parks in IDLE
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    bit_idx_next = bit_idx_reg;
    kept_next    = kept_reg;
    load_result  = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        cnt_next     = '0;
        bit_idx_next = MSB_IDX;
        kept_next    = '0;
        if (start_i) begin
          state_next = ST_SAMPLE;
        end
      end

      ST_SAMPLE: begin
        if (cnt_reg == SAMPLE_LAST) begin
          cnt_next   = '0;
          state_next = ST_CONVERT;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      ST_CONVERT: begin
        if (cnt_reg == SETTLE_LAST) begin
          // End of this bit's settle window: commit the verdict
          cnt_next  = '0;
          kept_next = final_code;
          if (bit_idx_reg == '0) begin
            state_next  = ST_DONE;
            load_result = 1'b1;
          end else begin
            bit_idx_next = bit_idx_reg - 1'b1;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      ST_DONE: begin
        cnt_next     = '0;
        bit_idx_next = MSB_IDX;
        kept_next    = '0;
        state_next   = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase

    if (!ena) begin
      state_next   = ST_IDLE;
      cnt_next     = '0;
      bit_idx_next = MSB_IDX;
      kept_next    = '0;
      load_result  = 1'b0;
    end
  end

  // Result register captures the final code as DONE is entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_reg <= '0;
    end else if (load_result) begin
      result_reg <= final_code;
    end
  end

  // Status outputs decode directly from the registered state
  assign sample_o   = (state_reg == ST_SAMPLE);
  assign busy_o     = (state_reg == ST_SAMPLE) || (state_reg == ST_CONVERT);
  assign done_o     = (state_reg == ST_DONE);
  assign dac_code_o = (state_reg == ST_CONVERT) ? (kept_reg | trial_mask) : '0;
  assign result_o   = result_reg;

`ifdef SAR_REF_MONITOR_ALARM_EN
  logic alarm_reg;

  // Window check on the final code, updated together with the result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alarm_reg <= 1'b0;
    end else if (load_result) begin
      alarm_reg <= (final_code < thr_lo_i) || (final_code > thr_hi_i);
    end
  end

  assign alarm_o = alarm_reg;
`else
  // Thresholds have no function in this build
  logic unused_thr;
  assign unused_thr = ^{thr_lo_i, thr_hi_i};
  assign alarm_o    = 1'b0;
`endif

endmodule

// File: tb/tb_sar_ref_monitor.sv
// Self-checking bench for sar_ref_monitor (default geometry 8/4/3).
// An ideal comparator (dac_code_o <= vin_code) closes the loop, so an ideal
// SAR must return vin_code; trial codes and timing follow from that.
module tb_sar_ref_monitor;

  localparam int N   = 8;
  localparam int S   = 4;
  localparam int T   = 3;
  localparam int LAT = S + N * T + 1;

`ifdef SAR_REF_MONITOR_ALARM_EN
  localparam logic ALARM_ON = 1'b1;
`else
  localparam logic ALARM_ON = 1'b0;
`endif

  typedef struct {
    logic [7:0] vin;
    logic [7:0] lo;
    logic [7:0] hi;
    int         again_at;
    logic [7:0] exp_result;
    logic       exp_alarm;
    logic [7:0] exp_first;
  } tvec_t;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       ena      = 1'b0;
  logic       start_i  = 1'b0;
  logic       comp_i;
  logic [7:0] thr_lo_i = 8'h00;
  logic [7:0] thr_hi_i = 8'h00;
  logic [7:0] vin_code = 8'h00;
  logic [7:0] dac_code_o;
  logic       sample_o;
  logic       busy_o;
  logic       done_o;
  logic [7:0] result_o;
  logic       alarm_o;

  int         vectors     = 0;
  int         miscompares = 0;
  logic [7:0] prev_result = 8'h00;
  logic       prev_alarm  = 1'b0;

  always #5 clk = ~clk;

  assign comp_i = (dac_code_o <= vin_code);

  sar_ref_monitor #(
    .N_BITS        (N),
    .SAMPLE_CYCLES (S),
    .SETTLE_CYCLES (T)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .start_i    (start_i),
    .comp_i     (comp_i),
    .thr_lo_i   (thr_lo_i),
    .thr_hi_i   (thr_hi_i),
    .dac_code_o (dac_code_o),
    .sample_o   (sample_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .result_o   (result_o),
    .alarm_o    (alarm_o)
  );

  function automatic logic [19:0] pack_obs();
    return {busy_o, sample_o, done_o, dac_code_o, result_o, alarm_o};
  endfunction

  function automatic logic [19:0] pack_exp(input logic b, input logic s, input logic d,
                                           input logic [7:0] dac, input logic [7:0] res,
                                           input logic al);
    return {b, s, d, dac, res, al};
  endfunction

  // Trial code for bit bp: the upper bits of vin already resolved, plus bit bp
  function automatic logic [7:0] trial_at(input logic [7:0] vin, input int bp);
    int v;
    v = ((int'(vin) >> (bp + 1)) << (bp + 1)) | (1 << bp);
    return v[7:0];
  endfunction

  function automatic logic model_alarm(input logic [7:0] v, input logic [7:0] lo,
                                       input logic [7:0] hi);
    return ALARM_ON && ((v < lo) || (v > hi));
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Expect a quiet idle block holding the last result for n cycles
  task automatic quiet(input int n, input string tag);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      check($sformatf("%s idle%0d", tag, c), 32'(pack_obs()),
            32'(pack_exp(1'b0, 1'b0, 1'b0, 8'h00, prev_result, prev_alarm)));
    end
  endtask

  // One full conversion, called at a negedge with the DUT idle; checks every cycle
  task automatic run_conv(input logic [7:0] vin, input logic [7:0] lo, input logic [7:0] hi,
                          input int again_at, input string tag,
                          output logic [7:0] got_res, output logic got_al,
                          output logic [7:0] got_first);
    logic        exp_al;
    logic [19:0] e;
    int          bp;
    exp_al    = model_alarm(vin, lo, hi);
    got_res   = 8'h00;
    got_al    = 1'b0;
    got_first = 8'h00;
    vin_code  = vin;
    thr_lo_i  = lo;
    thr_hi_i  = hi;
    start_i   = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    for (int c = 1; c <= LAT + 1; c++) begin
      @(negedge clk);
      if (c <= S) begin
        e = pack_exp(1'b1, 1'b1, 1'b0, 8'h00, prev_result, prev_alarm);
      end else if (c <= S + N * T) begin
        bp = N - 1 - (c - S - 1) / T;
        e  = pack_exp(1'b1, 1'b0, 1'b0, trial_at(vin, bp), prev_result, prev_alarm);
      end else if (c == LAT) begin
        e = pack_exp(1'b0, 1'b0, 1'b1, 8'h00, vin, exp_al);
      end else begin
        e = pack_exp(1'b0, 1'b0, 1'b0, 8'h00, vin, exp_al);
      end
      check($sformatf("%s cyc%0d", tag, c), 32'(pack_obs()), 32'(e));
      if (c == S + 1) got_first = dac_code_o;
      if (c == LAT) begin
        got_res = result_o;
        got_al  = alarm_o;
      end
      start_i = (c == again_at);
    end
    prev_result = vin;
    prev_alarm  = exp_al;
    $display("conv %s vin=%02h result=%02h alarm=%0b", tag, vin, got_res, got_al);
  endtask

  tvec_t      tbl[7];
  logic [7:0] r_res;
  logic       r_al;
  logic [7:0] r_first;
  int         done_cnt;
  int         done_at[2];

  initial begin
    tbl[0] = '{8'h00, 8'h40, 8'hC0, -1, 8'h00, ALARM_ON, 8'h80};
    tbl[1] = '{8'hFF, 8'h40, 8'hC0, -1, 8'hFF, ALARM_ON, 8'h80};
    tbl[2] = '{8'hD0, 8'h40, 8'hC0, -1, 8'hD0, ALARM_ON, 8'h80};
    tbl[3] = '{8'h80, 8'h40, 8'hC0, -1, 8'h80, 1'b0,     8'h80};
    tbl[4] = '{8'h3C, 8'h40, 8'hC0, 10, 8'h3C, ALARM_ON, 8'h80};
    tbl[5] = '{8'h7E, 8'h40, 8'hC0, -1, 8'h7E, 1'b0,     8'h80};
    tbl[6] = '{8'hA5, 8'h40, 8'hC0, -1, 8'hA5, 1'b0,     8'h80};

    // Reset state
    #2;
    check("reset outputs", 32'(pack_obs()), 32'(20'h0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ena   = 1'b1;

    // Directed table (ends on 0xA5 so the enable-drop case can see it held)
    for (int i = 0; i < 7; i++) begin
      run_conv(tbl[i].vin, tbl[i].lo, tbl[i].hi, tbl[i].again_at,
               $sformatf("tbl%0d", i), r_res, r_al, r_first);
      check($sformatf("tbl%0d result", i), 32'(r_res), 32'(tbl[i].exp_result));
      check($sformatf("tbl%0d alarm", i), 32'(r_al), 32'(tbl[i].exp_alarm));
      check($sformatf("tbl%0d first trial", i), 32'(r_first), 32'(tbl[i].exp_first));
      if (tbl[i].again_at >= 0) quiet(35, $sformatf("tbl%0d no-requeue", i));
    end

    // Enable dropped at cycle 15: IDLE next edge, last result held
    vin_code = 8'h11;
    start_i  = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    for (int c = 1; c <= 15; c++) @(negedge clk);
    ena = 1'b0;
    @(negedge clk);
    check("ena drop idle", 32'(pack_obs()),
          32'(pack_exp(1'b0, 1'b0, 1'b0, 8'h00, 8'hA5, prev_alarm)));
    start_i = 1'b1;
    quiet(3, "ena low start ignored");
    start_i = 1'b0;
    ena     = 1'b1;
    quiet(35, "ena restore");
    $display("seq ena-drop result=%02h", result_o);

    // Reset asserted at cycle 12 of a conversion
    vin_code = 8'h55;
    start_i  = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    for (int c = 1; c <= 12; c++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async reset", 32'(pack_obs()), 32'(20'h0));
    prev_result = 8'h00;
    prev_alarm  = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("in reset %0d", c), 32'(pack_obs()), 32'(20'h0));
    end
    rst_n = 1'b1;
    run_conv(8'h7E, 8'h40, 8'hC0, -1, "post-reset", r_res, r_al, r_first);
    check("post-reset result", 32'(r_res), 32'(8'h7E));

    // Back-to-back conversions with start_i held high
    done_cnt   = 0;
    done_at[0] = -1;
    done_at[1] = -1;
    vin_code   = 8'h5A;
    start_i    = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 1; c <= 2 * LAT + 3; c++) begin
      @(negedge clk);
      if (done_o) begin
        if (done_cnt < 2) done_at[done_cnt] = c;
        done_cnt++;
        if (done_cnt == 1) check("b2b first result", 32'(result_o), 32'(8'h5A));
      end
      if (c == LAT) vin_code = 8'hC3;
      if (c == LAT + 2) start_i = 1'b0;
    end
    check("b2b done count", 32'(done_cnt), 32'(2));
    check("b2b first done cycle", 32'(done_at[0]), 32'(LAT));
    check("b2b second done cycle", 32'(done_at[1]), 32'(2 * LAT + 1));
    check("b2b second result", 32'(result_o), 32'(8'hC3));
    prev_result = 8'hC3;
    prev_alarm  = model_alarm(8'hC3, thr_lo_i, thr_hi_i);
    $display("seq back-to-back dones=%0d result=%02h", done_cnt, result_o);
    quiet(33, "b2b tail");

    // Randomized conversions against the ideal-SAR model
    for (int i = 0; i < 24; i++) begin
      logic [7:0] v, lo, hi;
      int         again;
      v     = 8'($urandom_range(0, 255));
      lo    = 8'($urandom_range(0, 255));
      hi    = 8'($urandom_range(0, 255));
      again = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, LAT - 1)) : -1;
      run_conv(v, lo, hi, again, $sformatf("rnd%0d", i), r_res, r_al, r_first);
      check($sformatf("rnd%0d result", i), 32'(r_res), 32'(v));
      check($sformatf("rnd%0d alarm", i), 32'(r_al), 32'(model_alarm(v, lo, hi)));
      if (again >= 0) quiet(2, $sformatf("rnd%0d no-requeue", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
